dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit sitting between the CPU datapath and the word-addressed data memory. Accepts one byte/halfword/word load or store per handshake, converts the byte address to a word index, drives the memory's address/data/read/write strobes, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data. It is the initiator side of the data-memory interface; the memory itself is the responder.

## Interface
- ADDR_W, 9, word-index width of the attached memory (512 words)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE only; transfer when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word sizes
- resp_valid  out  1  one-cycle pulse, exactly one per accepted request
- resp_rdata  out  32  load result; 0 for stores and errors; held until next resp_valid
- resp_err  out  1  qualified by resp_valid: misaligned, illegal size, or out of range
- mem_address  out  32  word index, zero-extended from ADDR_W bits
- mem_dataIn  out  32  write word; 0 outside WR
- mem_readmode  out  1  read strobe
- mem_writemode  out  1  write strobe
- mem_dataOut  in  32  read word from memory

## Operation
- Byte order big-endian: byte offset 0 = bits [31:24], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
- Word index = req_addr[ADDR_W+1:2]; request, address, size, signed, write, wdata latched on acceptance.
- Error if: size 11; half with addr[0]=1; word with addr[1:0]≠0; any of req_addr[31:ADDR_W+2] set. Errors make no memory access.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE: req_ready=1. On transfer: error -> RESP (err=1); word store -> WR; load or sub-word store -> RD.
- RD: mem_readmode=1 for exactly this cycle -> CAP.
- CAP: strobes low; register mem_dataOut. Load -> RESP with extracted/extended data. Sub-word store -> WR with merged word (only addressed lanes replaced by req_wdata low bits).
- WR: mem_writemode=1 for exactly this cycle, mem_dataIn = full word (word store) or merged word -> RESP.
- RESP: resp_valid=1 -> IDLE.
- Strobes are never high in two consecutive cycles and never high together; memory sees a clean 0->1->0 event per access.
- mem_address stable from RD through WR; 0 in IDLE.

## Timing
- Reset values: state IDLE, req_ready 1 after reset deasserts (0 while reset high), resp_valid 0, resp_rdata 0, resp_err 0, mem_address 0, mem_dataIn 0, mem_readmode 0, mem_writemode 0.
- Acceptance edge T. Error: resp_valid at T+1. Word store: WR T+1, resp T+2. Load: RD T+1, CAP T+2, resp T+3. Sub-word store: RD T+1, CAP T+2, WR T+3, resp T+4.
- mem_dataOut sampled at end of CAP (one full cycle after read strobe).
- Next request accepted no earlier than the cycle after resp_valid (IDLE); back-to-back throughput = latency + 1.
- req_valid ignored outside IDLE and while reset high; inputs need only be valid on the transfer cycle.
- Reset mid-operation: next edge returns to IDLE, strobes 0, no resp_valid for the aborted request; a write whose WR cycle already occurred stays in memory; a partial RMW never writes.

## Test plan
- Word store/load: store 0xDEADBEEF to addr 0x10 -> writemode pulse, mem_address 4, resp at T+2; load word 0x10 -> resp_rdata 0xDEADBEEF at T+3, err 0.
- Byte load extension: memory word 4 = 0x80FF7F01; lb addr 0x10 -> 0xFFFFFF80; lbu 0x10 -> 0x00000080; lb 0x12 -> 0x0000007F; lh 0x12 -> 0x00007F01.
- Sub-word RMW: word 4 = 0x11223344; sb 0xAA at 0x11 -> word 0x11AA3344; sh 0xBEEF at 0x12 -> 0x11AABEEF; resp at T+4; strobes never overlap.
- Errors: lw 0x12, lh 0x11, size 11, lw 0x800 (ADDR_W=9) -> resp_err 1 at T+1, resp_rdata 0, no strobe.
- Reset during CAP of sb -> no writemode pulse, no resp, memory word unchanged, req_ready 1 after reset.
- Back-to-back requests with req_valid held high -> each accepted only in IDLE, one resp per request, order preserved.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU datapath and a word-addressed data memory.
// Converts byte-addressed byte/halfword/word requests into single-cycle
// read and write strobes. Sub-word stores use read-modify-write. Load data
// is returned big-endian, with sign or zero extension.
module dmem_lsu #(
    parameter int ADDR_W = 9
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_dataIn_o,
    output logic        mem_readmode_o,
    output logic        mem_writemode_o,
    input  logic [31:0] mem_dataOut_i
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         word_q, word_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                reqErr;
    logic [4:0]          byteShift;
    logic [4:0]          halfShift;
    logic [31:0]         shiftedByte;
    logic [31:0]         shiftedHalf;
    logic [31:0]         loadValue;
    logic [31:0]         laneMask;
    logic [31:0]         laneData;
    logic [31:0]         mergedWord;

    // Lane selection for the captured word: extraction for loads, merging for sub-word stores
    always_comb begin
        byteShift   = {~off_q, 3'b000};
        halfShift   = {~off_q[1], 4'b0000};
        shiftedByte = mem_dataOut_i >> byteShift;
        shiftedHalf = mem_dataOut_i >> halfShift;
        loadValue   = mem_dataOut_i;
        laneMask    = 32'h0000_0000;
        laneData    = 32'h0000_0000;
        case (size_q)
            2'b00: begin
                loadValue = signed_q ? {{24{shiftedByte[7]}}, shiftedByte[7:0]}
                                     : {24'h000000, shiftedByte[7:0]};
                laneMask  = 32'h0000_00FF << byteShift;
                laneData  = {24'h000000, word_q[7:0]} << byteShift;
            end
            2'b01: begin
                loadValue = signed_q ? {{16{shiftedHalf[15]}}, shiftedHalf[15:0]}
                                     : {16'h0000, shiftedHalf[15:0]};
                laneMask  = 32'h0000_FFFF << halfShift;
                laneData  = {16'h0000, word_q[15:0]} << halfShift;
            end
            default: begin
                loadValue = mem_dataOut_i;
            end
        endcase
        mergedWord = (mem_dataOut_i & ~laneMask) | (laneData & laneMask);
    end

    // Request legality: illegal size, misalignment, or address beyond the memory
    always_comb begin
        reqErr = 1'b0;
        if (req_size_i == 2'b11) begin
            reqErr = 1'b1;
        end
        if (req_size_i == 2'b01 && req_addr_i[0]) begin
            reqErr = 1'b1;
        end
        if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) begin
            reqErr = 1'b1;
        end
        if (|req_addr_i[31:ADDR_W+2]) begin
            reqErr = 1'b1;
        end
    end

    // Next-state logic: sequence IDLE -> (RD -> CAP) -> (WR) -> RESP per request
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        idx_d    = idx_q;
        word_d   = word_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    off_d    = req_addr_i[1:0];
                    idx_d    = req_addr_i[ADDR_W+1:2];
                    word_d   = req_wdata_i;
                    if (reqErr) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (req_write_i && req_size_i == 2'b10) ? WR : RD;
                    end
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (write_q) begin
                    word_d  = mergedWord;
                    state_d = WR;
                end else begin
                    rdata_d = loadValue;
                    state_d = RESP;
                end
            end
            WR: begin
                rdata_d = 32'h0000_0000;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            idx_q    <= '0;
            word_q   <= 32'h0000_0000;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decoded from the registered state, so strobes are glitch-free single-cycle pulses
    always_comb begin
        req_ready_o     = (state_q == IDLE) && !reset_i;
        resp_valid_o    = (state_q == RESP);
        resp_rdata_o    = rdata_q;
        resp_err_o      = err_q;
        mem_readmode_o  = (state_q == RD);
        mem_writemode_o = (state_q == WR);
        mem_dataIn_o    = (state_q == WR) ? word_q : 32'h0000_0000;
        mem_address_o   = 32'h0000_0000;
        if (state_q == RD || state_q == CAP || state_q == WR) begin
            mem_address_o = {{(32-ADDR_W){1'b0}}, idx_q};
        end
    end

endmodule
